fp_int_weight_serializer: RTL and testbench

//  Transmit side of the bit-serial weight interface of fp_int_mac. Accepts one parallel word
//  (FP16 activation + INT weight + precision) per valid/ready handshake. Drives the MAC's

---
 rtl/fp_int_weight_serializer.sv | 166 ++++++++++++++++
 tb/tb_fp_int_weight_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int_weight_serializer.sv
// Bit-serial weight transmitter for fp_int_mac: one parallel word in, one weight bit per clk out.
// Optional macro WSER_LSB_FIRST_EN: emit LSB first instead of MSB (sign) first.
module fp_int_weight_serializer #(
    parameter int ACT_WIDTH = 16,
    parameter int MAX_PREC  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [MAX_PREC-1:0]  in_w,
    input  logic [3:0]           in_precision,
    output logic                 valid,
    output logic [ACT_WIDTH-1:0] act,
    output logic                 w,
    output logic [3:0]           precision,
    output logic                 last,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] MAXP = 4'(MAX_PREC);

    state_t               state_q, state_d;
    logic                 pb_full_q, pb_full_d;
    logic [ACT_WIDTH-1:0] pb_act_q, pb_act_d;
    logic [MAX_PREC-1:0]  pb_w_q, pb_w_d;
    logic [3:0]           pb_prec_q, pb_prec_d;
    logic [MAX_PREC-1:0]  sr_q, sr_d;
    logic [ACT_WIDTH-1:0] act_q, act_d;
    logic [3:0]           prec_q, prec_d;
    logic [3:0]           idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 prec_ok;
    logic                 accept;
    logic                 push;
    logic                 is_last;
    logic                 bypass;
    logic                 pop;
    logic                 load;
    logic [3:0]           last_idx;
    logic [3:0]           new_prec;
    logic [MAX_PREC-1:0]  bit_sel;

    // Handshake, bit selection and word-boundary decisions
    always_comb begin
        prec_ok  = (in_precision != 4'd0) && (in_precision <= MAXP);
        in_ready = !pb_full_q && !rst;
        accept   = in_valid && in_ready;
        push     = accept && prec_ok;
`ifdef WSER_LSB_FIRST_EN
        last_idx = prec_q - 4'd1;
`else
        last_idx = 4'd0;
`endif
        is_last  = (state_q == SHIFT) && (idx_q == last_idx);
        // A word arriving on the final bit with PB empty goes straight into SR
        bypass   = is_last && !pb_full_q && push;
        pop      = pb_full_q && ((state_q == IDLE) || is_last);
        load     = pop || bypass;
        new_prec = pop ? pb_prec_q : in_precision;
        bit_sel  = MAX_PREC'(1) << idx_q;
        valid    = (state_q == SHIFT);
        w        = valid && |(sr_q & bit_sel);
        last     = is_last;
        act      = act_q;
        precision = prec_q;
        err      = err_q;
        word_cnt = cnt_q;
    end

    // Next-state for FSM, shift register, prefetch buffer and counters
    always_comb begin
        state_d   = state_q;
        pb_full_d = (pb_full_q && !pop) || (push && !bypass);
        pb_act_d  = pb_act_q;
        pb_w_d    = pb_w_q;
        pb_prec_d = pb_prec_q;
        sr_d      = sr_q;
        act_d     = act_q;
        prec_d    = prec_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = accept && !prec_ok;

        if (push && !bypass) begin
            pb_act_d  = in_act;
            pb_w_d    = in_w;
            pb_prec_d = in_precision;
        end

        if (is_last && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (pb_full_q) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (is_last) begin
                    state_d = load ? SHIFT : IDLE;
                end else begin
`ifdef WSER_LSB_FIRST_EN
                    idx_d = idx_q + 4'd1;
`else
                    idx_d = idx_q - 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sr_d   = pop ? pb_w_q : in_w;
            act_d  = pop ? pb_act_q : in_act;
            prec_d = new_prec;
`ifdef WSER_LSB_FIRST_EN
            idx_d  = 4'd0;
`else
            idx_d  = new_prec - 4'd1;
`endif
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pb_full_q <= 1'b0;
            pb_act_q  <= '0;
            pb_w_q    <= '0;
            pb_prec_q <= '0;
            sr_q      <= '0;
            act_q     <= '0;
            prec_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pb_full_q <= pb_full_d;
            pb_act_q  <= pb_act_d;
            pb_w_q    <= pb_w_d;
            pb_prec_q <= pb_prec_d;
            sr_q      <= sr_d;
            act_q     <= act_d;
            prec_q    <= prec_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fp_int_weight_serializer.sv
// Directed testbench for fp_int_weight_serializer.
// Table of single words plus hand-written streaming, gap, error and reset sequences.
module tb_fp_int_weight_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [7:0]  in_w;
    logic [3:0]  in_precision;
    logic        valid;
    logic [15:0] act;
    logic        w;
    logic [3:0]  precision;
    logic        last;
    logic        err;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [3:0]  prec;
        logic [7:0]  wv;
        logic [15:0] av;
        logic [7:0]  seq;
    } vec_t;

    vec_t vecs[7];

    fp_int_weight_serializer dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_act(in_act),
        .in_w(in_w),
        .in_precision(in_precision),
        .valid(valid),
        .act(act),
        .w(w),
        .precision(precision),
        .last(last),
        .err(err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] p, input logic [7:0] wv, input logic [15:0] av);
        int g;
        @(negedge clk);
        in_valid = 1'b1;
        in_precision = p;
        in_w = wv;
        in_act = av;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [3:0] p, input logic [7:0] seq, input logic [15:0] av);
        @(negedge clk);
        chk("latency_idle", {31'd0, valid}, 32'd0);
        for (int i = 0; i < int'(p); i++) begin
            @(negedge clk);
            chk("bit_valid", {31'd0, valid}, 32'd1);
            chk("bit_w", {31'd0, w}, {31'd0, seq[7-i]});
            chk("bit_last", {31'd0, last}, {31'd0, (i == int'(p) - 1)});
            chk("bit_act", {16'd0, act}, {16'd0, av});
            chk("bit_prec", {28'd0, precision}, {28'd0, p});
        end
        exp_cnt++;
        @(negedge clk);
        chk("post_valid", {31'd0, valid}, 32'd0);
        chk("word_cnt", {16'd0, word_cnt}, exp_cnt);
    endtask

    task automatic bad_prec(input logic [3:0] p);
        send(p, 8'h05, 16'h1111);
        @(negedge clk);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        chk("err_clear", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_novalid", {31'd0, valid}, 32'd0);
        end
        chk("err_cnt", {16'd0, word_cnt}, exp_cnt);
        chk("err_ready", {31'd0, in_ready}, 32'd1);
    endtask

    logic        mv[40];
    logic        mw[40];
    logic        ml[40];
    logic [15:0] ma[40];

    initial begin
        logic [11:0] s3;
        logic [15:0] a3[3];
        logic [7:0]  w3[3];
        int f;
        int g;

`ifdef WSER_LSB_FIRST_EN
        vecs[0] = '{4'd4, 8'h05, 16'h4569, 8'b1010_0000};
        vecs[1] = '{4'd8, 8'hB2, 16'h1234, 8'b0100_1101};
        vecs[2] = '{4'd1, 8'h01, 16'hFFFF, 8'b1000_0000};
        vecs[3] = '{4'd3, 8'h06, 16'h3C00, 8'b0110_0000};
        vecs[4] = '{4'd2, 8'hFE, 16'hABCD, 8'b0100_0000};
        vecs[5] = '{4'd4, 8'h03, 16'h0001, 8'b1100_0000};
        vecs[6] = '{4'd4, 8'h0A, 16'h0000, 8'b0101_0000};
        s3 = 12'b1010_0101_1010;
`else
        vecs[0] = '{4'd4, 8'h05, 16'h4569, 8'b0101_0000};
        vecs[1] = '{4'd8, 8'hB2, 16'h1234, 8'b1011_0010};
        vecs[2] = '{4'd1, 8'h01, 16'hFFFF, 8'b1000_0000};
        vecs[3] = '{4'd3, 8'h06, 16'h3C00, 8'b1100_0000};
        vecs[4] = '{4'd2, 8'hFE, 16'hABCD, 8'b1000_0000};
        vecs[5] = '{4'd4, 8'h03, 16'h0001, 8'b0011_0000};
        vecs[6] = '{4'd4, 8'h0A, 16'h0000, 8'b1010_0000};
        s3 = 12'b0101_1010_0101;
`endif
        a3[0] = 16'h4569; a3[1] = 16'h0000; a3[2] = 16'h4821;
        w3[0] = 8'h05;    w3[1] = 8'h0A;    w3[2] = 8'h05;

        rst = 1'b1;
        in_valid = 1'b0;
        in_act = '0;
        in_w = '0;
        in_precision = '0;
        #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_w", {31'd0, w}, 32'd0);
        chk("rst_last", {31'd0, last}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_act", {16'd0, act}, 32'd0);
        chk("rst_prec", {28'd0, precision}, 32'd0);
        chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            send(vecs[k].prec, vecs[k].wv, vecs[k].av);
            expect_word(vecs[k].prec, vecs[k].seq, vecs[k].av);
        end

        // three words streamed back-to-back
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_precision = 4'd4;
                    in_w = w3[k];
                    in_act = a3[k];
                    g = 0;
                    while (!in_ready && g < 50) begin
                        @(negedge clk);
                        g++;
                    end
                    @(posedge clk);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    mv[i] = valid;
                    mw[i] = w;
                    ml[i] = last;
                    ma[i] = act;
                end
            end
        join
        f = -1;
        for (int i = 0; i < 40; i++) begin
            if (f < 0 && mv[i]) f = i;
        end
        chk("b2b_start_found", {31'd0, (f >= 0 && f < 20)}, 32'd1);
        if (f < 0 || f >= 20) f = 0;
        for (int i = 0; i < 12; i++) begin
            chk("b2b_valid", {31'd0, mv[f+i]}, 32'd1);
            chk("b2b_w", {31'd0, mw[f+i]}, {31'd0, s3[11-i]});
            chk("b2b_last", {31'd0, ml[f+i]}, {31'd0, (i % 4 == 3)});
            chk("b2b_act", {16'd0, ma[f+i]}, {16'd0, a3[i/4]});
        end
        chk("b2b_end", {31'd0, mv[f+12]}, 32'd0);
        exp_cnt += 3;
        chk("b2b_cnt", {16'd0, word_cnt}, exp_cnt);

        // same word twice separated by idle input
        send(4'd4, 8'h0A, 16'h2222);
        expect_word(4'd4, vecs[6].seq, 16'h2222);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap_valid", {31'd0, valid}, 32'd0);
            chk("gap_ready", {31'd0, in_ready}, 32'd1);
        end
        send(4'd4, 8'h0A, 16'h2222);
        expect_word(4'd4, vecs[6].seq, 16'h2222);

        // illegal precisions
        bad_prec(4'd0);
        bad_prec(4'd9);

        // reset during the second bit
        send(vecs[0].prec, vecs[0].wv, vecs[0].av);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, valid}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_w", {31'd0, w}, 32'd0);
        chk("mid_rst_last", {31'd0, last}, 32'd0);
        chk("mid_rst_cnt", {16'd0, word_cnt}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        send(vecs[5].prec, vecs[5].wv, vecs[5].av);
        expect_word(vecs[5].prec, vecs[5].seq, vecs[5].av);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
